// File: rtl/iir_pkg.sv
// Shared types and sizing for the biquad MAC datapath.
// The accumulator has headroom for five full-scale 24x24 products.
package iir_pkg;

  localparam int DATA_W    = 24;
  localparam int COEF_FRAC = 22;
  localparam int ACC_W     = 52;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  typedef logic [2:0] tap_t;

  // Taps 0..4 are b0,b1,b2,a1,a2; tap 5 is the rounding/writeback cycle.
  localparam tap_t TAP_A1   = 3'd3;
  localparam tap_t TAP_LAST = 3'd4;
  localparam tap_t TAP_DONE = 3'd5;

endpackage

// File: rtl/iir_round_sat.sv
// Converts the Q.22 accumulator to a 24-bit sample: round half up, then
// clamp to the signed 24-bit range.
module iir_round_sat
  import iir_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] y
);

  localparam logic signed [ACC_W-1:0] HALF =
    {{(ACC_W-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    biased  = acc + HALF;
    shifted = biased >>> COEF_FRAC;
    if (shifted > MAX_V) begin
      y = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < MIN_V) begin
      y = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      y = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/iir_biquad_mac.sv
// Direct form I biquad computed with one shared unsigned multiplier:
// one tap per cycle, sign handled here, multiplier sits outside the block.
module iir_biquad_mac #(
  parameter int DATA_W    = 24,
  parameter int COEF_FRAC = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [DATA_W-1:0]     coef_b0,
  input  logic [DATA_W-1:0]     coef_b1,
  input  logic [DATA_W-1:0]     coef_b2,
  input  logic [DATA_W-1:0]     coef_a1,
  input  logic [DATA_W-1:0]     coef_a2,
  output logic [DATA_W-1:0]     mul_a,
  output logic [DATA_W-1:0]     mul_b,
  input  logic [2*DATA_W-1:0]   mul_p,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output iir_pkg::state_t       dbg_state
);

  localparam int ACC_W = iir_pkg::ACC_W;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid holds its payload stable until that edge.

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
  endfunction

  iir_pkg::state_t state, state_nxt;
  iir_pkg::tap_t   tap;

  logic [DATA_W-1:0] x0, x1, x2, y1, y2;
  logic [DATA_W-1:0] b0, b1, b2, a1, a2;
  logic [DATA_W-1:0] tap_data, tap_coef, rs_y;
  logic signed [ACC_W-1:0] acc, prod_ext, prod;
  logic mac_active, prod_neg;

  assign dbg_state = state;
  assign in_ready  = (state == iir_pkg::ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= iir_pkg::ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      iir_pkg::ST_IDLE: if (in_valid) state_nxt = iir_pkg::ST_MAC;
      iir_pkg::ST_MAC:  if (tap == iir_pkg::TAP_DONE) state_nxt = iir_pkg::ST_OUT;
      iir_pkg::ST_OUT:  if (out_ready) state_nxt = iir_pkg::ST_IDLE;
      default:          state_nxt = iir_pkg::ST_IDLE;
    endcase
  end

  always_comb begin
    tap_data = '0;
    tap_coef = '0;
    case (tap)
      3'd0:    begin tap_data = x0; tap_coef = b0; end
      3'd1:    begin tap_data = x1; tap_coef = b1; end
      3'd2:    begin tap_data = x2; tap_coef = b2; end
      3'd3:    begin tap_data = y1; tap_coef = a1; end
      3'd4:    begin tap_data = y2; tap_coef = a2; end
      default: begin tap_data = '0; tap_coef = '0; end
    endcase
  end

  // Feedback taps are subtracted, so they carry an extra sign inversion.
  always_comb begin
    mac_active = (state == iir_pkg::ST_MAC) && (tap <= iir_pkg::TAP_LAST);
    mul_a      = mac_active ? mag(tap_data) : '0;
    mul_b      = mac_active ? mag(tap_coef) : '0;
    prod_neg   = tap_data[DATA_W-1] ^ tap_coef[DATA_W-1] ^ (tap >= iir_pkg::TAP_A1);
    prod_ext   = ACC_W'(mul_p);
    prod       = prod_neg ? -prod_ext : prod_ext;
  end

  iir_round_sat u_round_sat (
    .acc (acc),
    .y   (rs_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tap       <= '0;
      acc       <= '0;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      b0        <= '0;
      b1        <= '0;
      b2        <= '0;
      a1        <= '0;
      a2        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        iir_pkg::ST_IDLE: begin
          if (in_valid) begin
            x0  <= in_data;
            b0  <= coef_b0;
            b1  <= coef_b1;
            b2  <= coef_b2;
            a1  <= coef_a1;
            a2  <= coef_a2;
            acc <= '0;
            tap <= '0;
          end
        end
        iir_pkg::ST_MAC: begin
          if (tap <= iir_pkg::TAP_LAST) begin
            acc <= acc + prod;
            tap <= tap + 3'd1;
          end else begin
            out_data  <= rs_y;
            out_valid <= 1'b1;
            x2        <= x1;
            x1        <= x0;
            y2        <= y1;
            y1        <= rs_y;
          end
        end
        iir_pkg::ST_OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
